bus_arbiter4: RTL and testbench
===============================

// Module: bus_arbiter4
// PURPOSE
// - Round-robin arbiter sharing the 16-bit 4:1 operand/write-back mux among four requesters.
// - Drives the mux select (sel) and a one-hot grant; the mux data path itself is external.
// - Sits beside the mux in the datapath. Bounds each owner's tenure so no requester starves.
// PARAMETERS
// - MAX_HOLD  default 4  max consecutive cycles one owner keeps the mux while others wait (>=1)
// - CNT_W     default 3  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
// - clk       in   1   single clock, rising edge
// - rst_n     in   1   asynchronous, active-low reset
// - req       in   4   req[i]=1: requester i wants the mux; held until done
// - lock      in   1   owner requests tenure extension (used only with BUS_ARB_LOCK_EN)
// - gnt       out  4   one-hot grant, registered; all zero when idle
// - sel       out  2   mux select = index of gnt bit, registered
// - busy      out  1   1 while any grant is active
// BEHAVIOUR
// - Reset (async assert, sync release): gnt=0, sel=2'b00, busy=0, state=IDLE, hold_cnt=0, last=3.
//   With last=3, requester 0 has top priority first.
// - States: IDLE, GRANT. All outputs come straight from flops; no comb path req->gnt.
// - Pick: the first set req bit scanning last+1, last+2, ... mod 4 (wrap 3->0).
// - IDLE: if |req, next cycle GRANT to pick; gnt/sel/busy update; last<=pick; hold_cnt<=0.
//   Latency is 1 clk from req seen to gnt.
// - GRANT, owner o:
//   * req[o]=0: if other reqs pending, grant pick next cycle (no idle bubble; hold_cnt<=0).
//     Otherwise go to IDLE, gnt<=0, busy<=0, sel holds its last value.
//   * req[o]=1, no other req: keep grant; hold_cnt saturates at MAX_HOLD-1 (no wrap).
//   * req[o]=1, other req pending, hold_cnt==MAX_HOLD-1: forced rotate to pick (excludes o).
//   * Otherwise hold_cnt++.
// - Simultaneous release and new req from same requester: the release wins. Requester
//   re-arbitrates from IDLE or rotation; o is lowest priority right after its own grant.
// - sel changes only on the same edge as gnt. gnt is never multi-hot.
//   gnt never switches without passing through a legal transition above.
// - Mid-operation reset: outputs drop to reset values immediately (async); tenure is not preserved.
// - req bits with no grant are level-sensitive. Dropping req before grant withdraws it silently.
// CONFIGURATION
// - BUS_ARB_LOCK_EN defined: with lock=1 and req[o]=1, forced rotation is suppressed.
//   hold_cnt is frozen; lock is ignored unless state is GRANT.
// - BUS_ARB_LOCK_EN undefined: lock port exists but is unused. Tenure is always bounded by MAX_HOLD.
// STRUCTURE
// - Package bus_arb_pkg holds:
//   * N_REQ=4, SEL_W=2
//   * typedef enum logic {IDLE, GRANT} arb_state_t
//   * function onehot_to_idx
// - Sub-module rr_pick4: combinational rotating-priority picker (req, last, mask -> pick, any).
// - Top level holds the FSM, hold counter, last pointer and output flops.
// TESTING
// - Reset, then req=4'b0001 -> gnt=0001 and sel=00 one clk later; busy=1.
// - req=4'b1111 held, MAX_HOLD=4 -> grants 0,1,2,3,0 each for 4 clks, sel 00,01,10,11,00.
// - Owner 2 drops req while req[3]=1 -> next clk gnt=1000 and sel=11, with no idle cycle.
// - Owner 1 alone holds req for 20 clks -> gnt stays 0010 and hold_cnt stays saturated.
//   Then req[0] rises -> rotate to 0 within 1 clk.
// - rst_n low mid-grant (gnt=0100) -> gnt=0, sel=00, busy=0 before the next edge.
//   After release with req=1111 -> gnt=0001.
// - BUS_ARB_LOCK_EN and lock=1 with owner 0 and req=0011 -> gnt stays 0001 beyond 4 clks.
//   lock=0 -> gnt=0010 next clk.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared constants, state type and index helpers for the
// four-requester round-robin mux arbiter (bus_arbiter4 / rr_pick4).
package bus_arb_pkg;

   // Requester count and matching mux select width.
   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   // Arbiter FSM: IDLE (no owner) and GRANT (one owner holds the mux).
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // One-hot grant vector to owner index; returns 0 for an all-zero vector.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            idx = SEL_W'(i);
         end
      end
      return idx;
   endfunction

   // Owner index to one-hot grant vector.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (idx == SEL_W'(i)) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// rr_pick4: combinational rotating-priority picker. Scans req (with masked
// bits removed) starting at last+1 and wrapping 3->0; the first set bit wins.
// any is 1 when at least one unmasked request exists.
module rr_pick4
   import bus_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   input  logic [N_REQ-1:0] mask,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [N_REQ-1:0] eligible;

   assign eligible = req & ~mask;

   // Scan last+1 .. last+4; last itself is visited last, i.e. lowest priority.
   always_comb begin
      logic [SEL_W-1:0] idx;
      pick = last;
      any  = 1'b0;
      idx  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = last + SEL_W'(k);
         if (!any && eligible[idx]) begin
            any  = 1'b1;
            pick = idx;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter for the shared 16-bit 4:1 operand /
// write-back mux. Drives registered one-hot gnt, mux select sel and busy.
// Each owner's tenure is bounded by MAX_HOLD cycles while others wait.
// Build option: define BUS_ARB_LOCK_EN to let the owner hold the mux past
// MAX_HOLD with lock=1; otherwise lock is accepted but ignored.
module bus_arbiter4
   import bus_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             lock,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy
);

   localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [N_REQ-1:0] gnt_d;
   logic [SEL_W-1:0] sel_d;
   logic             busy_d;

   logic [SEL_W-1:0] owner;
   logic             owner_req;
   logic [N_REQ-1:0] pick_mask;
   logic [SEL_W-1:0] pick;
   logic             pick_any;
   logic             lock_act;

   // gnt is one-hot while in GRANT, so it directly names the owner.
   assign owner     = onehot_to_idx(gnt);
   assign owner_req = |(req & gnt);

   // During a tenure the owner is excluded so a forced rotation never re-picks it.
   assign pick_mask = (state_q == GRANT) ? gnt : '0;

`ifdef BUS_ARB_LOCK_EN
   // Lock only matters while an owner exists and still wants the mux.
   assign lock_act = lock && (state_q == GRANT) && owner_req;
`else
   logic unused_lock;
   assign unused_lock = lock;
   assign lock_act    = 1'b0;
`endif

   rr_pick4 u_pick (
      .req  (req),
      .last (last_q),
      .mask (pick_mask),
      .pick (pick),
      .any  (pick_any)
   );

   // Next-state: FSM transitions, hold counter, last pointer and output values.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      gnt_d   = gnt;
      sel_d   = sel;
      busy_d  = busy;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               gnt_d   = idx_to_onehot(pick);
               sel_d   = pick;
               busy_d  = 1'b1;
               last_d  = pick;
               hold_d  = '0;
            end
         end

         GRANT: begin
            if (!owner_req) begin
               if (pick_any) begin
                  // Hand over on the same edge; no idle bubble.
                  gnt_d  = idx_to_onehot(pick);
                  sel_d  = pick;
                  last_d = pick;
                  hold_d = '0;
               end else begin
                  // sel keeps its value so the mux input stays stable while idle.
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else if (lock_act) begin
               hold_d = hold_q;
            end else if (!pick_any) begin
               // Sole requester: count up but saturate so a late contender
               // forces a rotation on the very next edge.
               if (hold_q != HoldMax) begin
                  hold_d = hold_q + CNT_W'(1);
               end
            end else if (hold_q == HoldMax) begin
               gnt_d  = idx_to_onehot(pick);
               sel_d  = pick;
               last_d = pick;
               hold_d = '0;
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State and output registers; reset to idle with requester 0 first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= SEL_W'(N_REQ - 1);
         gnt     <= '0;
         sel     <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         gnt     <= gnt_d;
         sel     <= sel_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: directed, table-driven bench for bus_arbiter4 with
// MAX_HOLD=4, plus hand-written multi-cycle sequences.
module tb_bus_arbiter4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       lock;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   vec_t vecs[10];

   bus_arbiter4 #(
      .MAX_HOLD (4),
      .CNT_W    (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .lock  (lock),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                        input logic eb);
      checks++;
      if (gnt !== eg || sel !== es || busy !== eb) begin
         errors++;
         $display("FAIL %s: got gnt=%b sel=%b busy=%b, want gnt=%b sel=%b busy=%b",
                  name, gnt, sel, busy, eg, es, eb);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      lock  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // name, req applied, expected gnt/sel/busy after the next edge
      vecs[0] = '{"single_req0",      4'b0001, 4'b0001, 2'b00, 1'b1};
      vecs[1] = '{"release_idle",     4'b0000, 4'b0000, 2'b00, 1'b0};
      vecs[2] = '{"req2_from_idle",   4'b0100, 4'b0100, 2'b10, 1'b1};
      vecs[3] = '{"idle_sel_holds",   4'b0000, 4'b0000, 2'b10, 1'b0};
      vecs[4] = '{"req3_from_idle",   4'b1000, 4'b1000, 2'b11, 1'b1};
      vecs[5] = '{"owner3_keeps",     4'b1100, 4'b1000, 2'b11, 1'b1};
      vecs[6] = '{"handover_to2",     4'b0100, 4'b0100, 2'b10, 1'b1};
      vecs[7] = '{"owner2_keeps",     4'b0101, 4'b0100, 2'b10, 1'b1};
      vecs[8] = '{"handover_to0",     4'b0001, 4'b0001, 2'b00, 1'b1};
      vecs[9] = '{"final_idle",       4'b0000, 4'b0000, 2'b00, 1'b0};

      do_reset();
      check("reset_state", 4'b0000, 2'b00, 1'b0);

      for (int i = 0; i < 10; i++) begin
         req = vecs[i].req;
         tick();
         check(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      end

      // All four requesting: four-cycle tenures in order 0,1,2,3,0.
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         logic [1:0] o;
         logic [3:0] oh;
         tick();
         o  = 2'((c / 4) % 4);
         oh = 4'b0001 << o;
         check($sformatf("rr_all_c%0d", c), oh, o, 1'b1);
      end

      // Owner 2 releases while 3 waits: immediate handover, no bubble.
      do_reset();
      req = 4'b0100;
      tick();
      check("own2_grant", 4'b0100, 2'b10, 1'b1);
      req = 4'b1100;
      tick();
      check("own2_hold", 4'b0100, 2'b10, 1'b1);
      req = 4'b1000;
      tick();
      check("own2_to_3", 4'b1000, 2'b11, 1'b1);

      // Lone owner 1 for 20 cycles, then requester 0 forces a rotation next edge.
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 20; c++) begin
         tick();
         check($sformatf("alone1_c%0d", c), 4'b0010, 2'b01, 1'b1);
      end
      req = 4'b0011;
      tick();
      check("alone1_rot0", 4'b0001, 2'b00, 1'b1);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      req = 4'b0100;
      tick();
      check("pre_rst_grant", 4'b0100, 2'b10, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 4'b0000, 2'b00, 1'b0);
      req = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_rr0", 4'b0001, 2'b00, 1'b1);

      do_reset();
      req = 4'b0011;
`ifdef BUS_ARB_LOCK_EN
      // Hold count reaches its limit, then lock keeps owner 0 well past it.
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("lock_pre_c%0d", c), 4'b0001, 2'b00, 1'b1);
      end
      lock = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("lock_hold_c%0d", c), 4'b0001, 2'b00, 1'b1);
      end
      lock = 1'b0;
      tick();
      check("lock_release", 4'b0010, 2'b01, 1'b1);
`else
      // Without the lock feature, lock=1 must not extend the tenure.
      lock = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("nolock_c%0d", c), 4'b0001, 2'b00, 1'b1);
      end
      tick();
      check("nolock_rot", 4'b0010, 2'b01, 1'b1);
      lock = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
